// File: rtl/rot_arbiter_pkg.sv
// Shared state encoding and datapath widths for the round-robin rotate arbiter.
package rot_arbiter_pkg;
  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic [1:0] {IDLE, ROT, RESP} state_t;
endpackage

// File: rtl/rot_core.sv
// Purely combinational 8-bit right rotate by 0..7: y[i] = a[(i+amt) mod 8].
module rot_core import rot_arbiter_pkg::*; (
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] y
);

  logic [AMT_W-1:0] idx;

  // The 3-bit index add wraps modulo 8 on its own.
  always_comb begin
    y   = '0;
    idx = '0;
    for (int i = 0; i < DATA_W; i++) begin
      idx  = AMT_W'(i) + amt;
      y[i] = a[idx];
    end
  end

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one rot_core between NREQ requesters.
// Optional macro ROT_ARBITER_DIR_EN adds per-job rotate direction (req_dir/rsp_dir).
module rot_arbiter import rot_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [DATA_W*NREQ-1:0] req_data,
  input  logic [AMT_W*NREQ-1:0]  req_amt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [ID_W-1:0]        rsp_id
`ifdef ROT_ARBITER_DIR_EN
  ,
  input  logic [NREQ-1:0]        req_dir,
  output logic                   rsp_dir
`endif
);

  localparam int SW = ID_W + 1;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_id;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [SW-1:0]     scan;
  logic [DATA_W-1:0] sel_data, cap_data, rot_y;
  logic [AMT_W-1:0]  sel_amt, cap_amt, eff_amt;
  logic [ID_W-1:0]   cap_id;
`ifdef ROT_ARBITER_DIR_EN
  logic              sel_dir, cap_dir;
`endif

  // Scan last_id+1, last_id+2, ... modulo NREQ; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = {1'b0, last_id} + SW'(k);
      if (scan >= SW'(NREQ))
        scan = scan - SW'(NREQ);
      if (!win_found && req_valid[scan[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    sel_data  = '0;
    sel_amt   = '0;
`ifdef ROT_ARBITER_DIR_EN
    sel_dir   = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == ID_W'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_amt  = req_amt[i*AMT_W +: AMT_W];
`ifdef ROT_ARBITER_DIR_EN
        sel_dir  = req_dir[i];
`endif
        req_ready[i] = (state == IDLE) && win_found;
      end
    end
    case (state)
      IDLE:    if (win_found) state_nxt = ROT;
      ROT:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Left rotate by k is a right rotate by (8-k) mod 8, i.e. the negated amount.
`ifdef ROT_ARBITER_DIR_EN
  assign eff_amt = cap_dir ? (AMT_W'(0) - cap_amt) : cap_amt;
`else
  assign eff_amt = cap_amt;
`endif

  rot_core u_rot_core (
    .a   (cap_data),
    .amt (eff_amt),
    .y   (rot_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_id  <= ID_W'(NREQ - 1);
      cap_data <= '0;
      cap_amt  <= '0;
      cap_id   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
`ifdef ROT_ARBITER_DIR_EN
      cap_dir  <= 1'b0;
      rsp_dir  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && win_found) begin
        cap_data <= sel_data;
        cap_amt  <= sel_amt;
        cap_id   <= win_id;
        last_id  <= win_id;
`ifdef ROT_ARBITER_DIR_EN
        cap_dir  <= sel_dir;
`endif
      end
      if (state == ROT) begin
        rsp_data <= rot_y;
        rsp_id   <= cap_id;
`ifdef ROT_ARBITER_DIR_EN
        rsp_dir  <= cap_dir;
`endif
      end
    end
  end

  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_rot_arbiter.sv
// Directed self-checking bench for rot_arbiter (NREQ=4); covers ROT_ARBITER_DIR_EN when defined.
module tb_rot_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [11:0] req_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
`ifdef ROT_ARBITER_DIR_EN
  logic [3:0]  req_dir;
  logic        rsp_dir;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] fexp  [4] = '{8'h81, 8'hC0, 8'h60, 8'h30};
  logic [7:0] sweep [8] = '{8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B};

  rot_arbiter #(.NREQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef ROT_ARBITER_DIR_EN
    ,
    .req_dir   (req_dir),
    .rsp_dir   (rsp_dir)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic rr);
    req_valid = valid;
    rsp_ready = rr;
  endtask

  task automatic setJob(input int id, input logic [7:0] d, input logic [2:0] a);
    req_data[id*8 +: 8] = d;
    req_amt[id*3 +: 3]  = a;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one job from an IDLE negedge and returns at the next IDLE negedge.
  task automatic doJob(input int id, input logic [7:0] d, input logic [2:0] a,
                       input logic [7:0] exp, input string tag);
    setJob(id, d, a);
    applyStimulus(4'b0001 << id, 1'b1);
    #1;
    checkOutput({tag, "_rdy"}, req_ready, 4'b0001 << id);
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_rot_valid"}, rsp_valid, 0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, rsp_valid, 1);
    checkOutput({tag, "_data"}, rsp_data, exp);
    checkOutput({tag, "_id"}, rsp_id, id);
`ifdef ROT_ARBITER_DIR_EN
    checkOutput({tag, "_dir"}, rsp_dir, req_dir[id]);
`endif
    @(negedge clk);
    checkOutput({tag, "_idle_valid"}, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_data  = '0;
    req_amt   = '0;
`ifdef ROT_ARBITER_DIR_EN
    req_dir   = '0;
`endif
    applyStimulus(4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", rsp_valid, 0);
    checkOutput("reset_data", rsp_data, 0);
    checkOutput("reset_id", rsp_id, 0);
    checkOutput("reset_ready", req_ready, 0);
    reset = 1'b0;

    // First job after reset: requester 0 has priority.
    doJob(0, 8'h81, 3'd1, 8'hC0, "first");

    // Fairness from a fresh pointer with all requesters valid.
    doReset();
    for (int i = 0; i < 4; i++) setJob(i, 8'h81, 3'(i));
    applyStimulus(4'b1111, 1'b1);
    for (int g = 0; g < 5; g++) begin
      #1;
      checkOutput("rr_grant", req_ready, 4'b0001 << (g % 4));
      @(negedge clk);
      @(negedge clk);
      checkOutput("rr_valid", rsp_valid, 1);
      checkOutput("rr_id", rsp_id, g % 4);
      checkOutput("rr_data", rsp_data, fexp[g % 4]);
      if (g == 4) applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
    end

    // Backpressure: response held stable, no grants while waiting.
    setJob(2, 8'h01, 3'd3);
    applyStimulus(4'b0100, 1'b0);
    #1;
    checkOutput("hold_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    applyStimulus(4'b1111, 1'b0);
    @(negedge clk);
    checkOutput("hold_rot_ready", req_ready, 0);
    checkOutput("hold_rot_valid", rsp_valid, 0);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", rsp_valid, 1);
      checkOutput("hold_data", rsp_data, 8'h20);
      checkOutput("hold_id", rsp_id, 2);
      checkOutput("hold_ready", req_ready, 0);
      if (h == 4) applyStimulus(4'b1111, 1'b1);
    end
    @(negedge clk);
    checkOutput("hold_release_valid", rsp_valid, 0);
    checkOutput("hold_next_grant", req_ready, 4'b1000);
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);

    // Reset while in RESP discards the job and restores the pointer.
    setJob(1, 8'h3C, 3'd2);
    applyStimulus(4'b0010, 1'b0);
    #1;
    checkOutput("rst_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pre_valid", rsp_valid, 1);
    checkOutput("rst_pre_data", rsp_data, 8'h0F);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid", rsp_valid, 0);
    checkOutput("rst_data", rsp_data, 0);
    checkOutput("rst_id", rsp_id, 0);
    reset = 1'b0;
    setJob(0, 8'h81, 3'd0);
    applyStimulus(4'b0101, 1'b1);
    #1;
    checkOutput("rst_ptr_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ptr_id", rsp_id, 0);
    checkOutput("rst_ptr_data", rsp_data, 8'h81);
    @(negedge clk);

    // Amount sweep from a single active requester (pointer wraps every job).
    for (int a = 0; a < 8; a++)
      doJob(3, 8'hA5, 3'(a), sweep[a], "sweep");

`ifdef ROT_ARBITER_DIR_EN
    req_dir = 4'b0001;
    doJob(0, 8'h81, 3'd1, 8'h03, "dir_left");
    req_dir = 4'b0000;
    doJob(0, 8'h81, 3'd1, 8'hC0, "dir_right");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rot_arbiter.md
Name: rot_arbiter

Overview:
- Shares one 8-bit right-rotate datapath between NREQ requesters using round-robin arbitration.
- Each requester presents a data byte and a rotate amount over a valid/ready handshake.
- The arbiter serialises the jobs through the rotator and returns each result on a single response channel, tagged with the requester id.
- Sits between client blocks and the rotator, so the rotator itself is never duplicated.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_data  in  8*NREQ  packed job bytes; requester i uses bits [8i+7:8i].
- req_amt  in  3*NREQ  packed rotate amounts; requester i uses bits [3i+2:3i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_data  out  8  rotated byte.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.

Behaviour:
- Rotate rule: rsp_data[i] = a[(i+amt) mod 8], i.e. rotate right by amt.
  - Example: a=0x81, amt=1 gives 0xC0.
  - amt=0 passes a unchanged.
- Reset: all outputs and registers clear.
  - state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
  - Round-robin pointer last_id=NREQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE: req_ready[w]=1 combinationally for winner w, the first i with req_valid[i]=1 scanning last_id+1, last_id+2, ... mod NREQ.
    - Handshake (req_valid[w]&req_ready[w]): capture data, amt and id=w; set last_id=w; go to ROT.
    - No req_valid: stay in IDLE, req_ready=0.
  - ROT: drive the captured operands into the rotator and register the result into rsp_data/rsp_id.
    - Set rsp_valid=1; go to RESP. req_ready=0.
  - RESP: hold rsp_valid, rsp_data and rsp_id stable until rsp_ready=1.
    - On rsp_ready=1: rsp_valid=0 next cycle; go to IDLE. req_ready=0.
- Timing:
  - Latency: rsp_valid rises 2 cycles after the accepting edge.
  - Peak throughput: one job per 3 cycles.
- Handshake rules:
  - req_ready never asserts outside IDLE, and never to a requester with req_valid=0.
  - A requester may drop req_valid before acceptance. The winner is recomputed every IDLE cycle, with no lock.
  - rsp_ready held high continuously gives back-to-back 3-cycle jobs.
  - rsp_ready may be asserted before rsp_valid; it is ignored outside RESP.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0,...
  - No requester waits more than NREQ grants.
- Boundaries:
  - Single active requester: granted repeatedly regardless of pointer.
  - last_id=NREQ-1 wraps the scan to 0.
  - Reset in ROT or RESP: job discarded, outputs return to reset values on the next edge, pointer reset.

Optional Feature:
- Macro ROT_ARBITER_DIR_EN.
- Defined:
  - Extra input req_dir (NREQ bits); 1 = rotate left, captured with the job.
  - Left rotate by k is implemented as right rotate by (8-k) mod 8. Example: 0x81 left 1 gives 0x03.
  - Extra output rsp_dir (1 bit) echoes the captured direction.
- Undefined: ports absent; every job rotates right.

Decomposition:
- Shared package rot_arbiter_pkg:
  - state enum {IDLE, ROT, RESP}.
  - constants DATA_W=8 and AMT_W=3.
- One sub-module, rot_core: purely combinational 8-bit right rotate by 0..7, instantiated once inside rot_arbiter.

Test Plan:
- After reset, only req0 valid with data=0x81, amt=1, rsp_ready=1 -> req_ready=4'b0001 in the first cycle; rsp_valid 2 cycles after accept with rsp_data=0xC0, rsp_id=0.
- All 4 valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles; each rsp_id matches its grant.
- req2 job 0x01 amt=3, rsp_ready held 0 for 5 cycles -> rsp_valid=1 with rsp_data=0x20, rsp_id=2 stable for all 5 cycles; req_ready stays 0; IDLE is re-entered the cycle after rsp_ready=1.
- reset pulsed during RESP -> next edge gives rsp_valid=0, rsp_data=0, state IDLE; next grant goes to requester 0 even if last_id was 1.
- amt sweep 0..7 on 0xA5 -> outputs 0xA5,0xD2,0x69,0xB4,0x5A,0x2D,0x96,0x4B.
- With ROT_ARBITER_DIR_EN: 0x81, amt=1, dir=1 -> rsp_data=0x03, rsp_dir=1.
